fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage pipelined processor, directly upstream of decode. Owns the program counter, drives the instruction-memory address, and loads the fetch/decode (F/D) pipeline latch with the fetched instruction, its PC+1 and a valid bit. Accepts stall requests from hazard logic and redirect requests from branch/jump resolution in execute. Maintains fetch and bubble performance counters.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- NOP, 32'h0000_0000, instruction word written into F/D on a bubble.

Ports:
- clock  in  1  the one clock of the block; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and F/D (load-use hazard, multdiv busy).
- redirect  in  1  taken branch/jump resolved in execute.
- redirect_target  in  32  next PC when redirect=1.
- address_imem  out  32  PC; the word address presented to imem.
- q_imem  in  32  instruction at address_imem, valid before the next rising edge.
- fd_pc  out  32  PC+1 of the instruction in F/D.
- fd_insn  out  32  instruction in F/D.
- fd_valid  out  1  F/D holds a real instruction (0 = bubble).
- fetch_count  out  32  instructions loaded into F/D as valid.
- bubble_count  out  32  bubbles inserted by redirect.

## Operation
- Priority per edge: reset > redirect > stall > normal advance.
- reset: PC<=RESET_PC; fd_insn<=NOP; fd_pc<=0; fd_valid<=0; both counters<=0.
- redirect (stall ignored): PC<=redirect_target; fd_insn<=NOP; fd_pc<=0; fd_valid<=0; bubble_count+=1. Instruction currently on q_imem is discarded.
- stall (no redirect): PC, fd_pc, fd_insn, fd_valid, counters all hold.
- normal: PC<=PC+1; fd_insn<=q_imem; fd_pc<=PC+1; fd_valid<=1; fetch_count+=1.
- PC+1 computed with 32-bit unsigned add; 32'hFFFF_FFFF+1 wraps to 0, no flag.
- Counters are 32-bit, wrap to 0 on overflow, never saturate.
- redirect_target taken as-is; no alignment or range check (word-addressed).
- No state machine beyond PC/F/D registers; bubble-vs-valid captured in fd_valid only.
- Squashing of instructions already past F/D is downstream's responsibility.

## Timing
- All outputs registered; address_imem is the PC register output directly.
- Reset values: address_imem=RESET_PC, fd_pc=0, fd_insn=NOP, fd_valid=0, fetch_count=0, bubble_count=0.
- Fetch latency: instruction at address A appears on fd_insn one edge after address_imem=A, with fd_pc=A+1.
- Redirect penalty: edge N (redirect=1) inserts bubble and sets PC=target; edge N+1 loads imem[target] into F/D. One bubble per redirect.
- Redirect asserted on consecutive cycles: each edge applies the newest target and inserts another bubble.
- Stall held k cycles: outputs frozen for k edges; the first non-stalled edge loads q_imem for the held PC.
- reset asserted mid-operation: takes effect at the next edge regardless of stall/redirect; first valid fetch one edge after reset deasserts.

## Structure
- Shared processor package: RESET_PC default, NOP encoding, PC/instruction width constant (32).
- PC+1 uses the codebase's existing 32-bit CLA adder; PC and F/D storage use the existing 32-bit register (with en/clr) instances.
- No new sub-module; counters and next-PC mux live in fetch_stage.

## Test plan
- Reset then free-run, imem[i]=32'h1000_0000+i: after 3 edges fd_insn=32'h1000_0002, fd_pc=3, fd_valid=1, fetch_count=3, address_imem=3.
- stall high for 2 edges while PC=5: address_imem stays 5, fd unchanged, fetch_count unchanged; next edge fd_insn=imem[5], fd_pc=6.
- redirect=1, target=32'h40, stall=1 same edge: fd_valid=0, fd_insn=0, address_imem=32'h40, bubble_count=1; next edge fd_insn=imem[0x40], fd_pc=32'h41.
- Back-to-back redirects to 0x10 then 0x20: two bubbles, bubble_count=2, address_imem=0x20, then imem[0x20] loads.
- Redirect to 32'hFFFF_FFFF then advance: fd_pc=0, address_imem=0 (wrap).
- reset asserted while stall=1 and redirect=1: next edge all outputs equal reset values.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared processor package.
// Holds the machine word width and the default reset PC / NOP encoding
// used by the fetch stage and any other stage that must agree on them.
package fetch_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'd0;
  localparam logic [WORD_W-1:0] NOP_DEFAULT      = 32'h0000_0000;

  // Wrapping increment used by the event counters; overflow rolls to zero.
  function automatic logic [WORD_W-1:0] wrap_inc(input logic [WORD_W-1:0] v);
    return v + {{(WORD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder.
// Built from eight 4-bit lookahead groups; group carries are chained
// through each group's generate/propagate pair.
// Ports:
//   a, b  in  32  operands
//   cin   in  1   carry in
//   sum   out 32  a + b + cin, modulo 2^32 (carry out discarded)
module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c = '0;
    c[0] = cin;
    for (int blk = 0; blk < 8; blk++) begin
      // Carries inside the group are expanded from the group carry-in so
      // no bit waits on its lower neighbour.
      c[4*blk+1] = g[4*blk] | (p[4*blk] & c[4*blk]);
      c[4*blk+2] = g[4*blk+1]
                 | (p[4*blk+1] & g[4*blk])
                 | (p[4*blk+1] & p[4*blk] & c[4*blk]);
      c[4*blk+3] = g[4*blk+2]
                 | (p[4*blk+2] & g[4*blk+1])
                 | (p[4*blk+2] & p[4*blk+1] & g[4*blk])
                 | (p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
      c[4*blk+4] = g[4*blk+3]
                 | (p[4*blk+3] & g[4*blk+2])
                 | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
                 | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk])
                 | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
    end
  end

  assign sum = p ^ c[31:0];

endmodule

// File: rtl/register_en_clr.sv
// Register with load enable and synchronous clear.
// Clear has priority over enable and loads CLR_VAL.
// Ports:
//   clock in  1      rising-edge clock
//   clr   in  1      synchronous clear (active-high)
//   en    in  1      load enable
//   d     in  WIDTH  next value
//   q     out WIDTH  stored value
module register_en_clr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the PC, presents it to instruction memory and loads the F/D latch
// with the fetched word, its PC+1 and a valid bit. A redirect from execute
// replaces the PC and inserts a bubble; a stall freezes PC and F/D.
// Priority on every edge: reset > redirect > stall > advance.
// Ports:
//   clock           in  1   clock, all updates on rising edge
//   reset           in  1   synchronous active-high reset
//   stall           in  1   hold PC and F/D
//   redirect        in  1   taken branch/jump from execute
//   redirect_target in  32  next PC when redirect=1
//   address_imem    out 32  PC (word address to imem)
//   q_imem          in  32  instruction at address_imem
//   fd_pc           out 32  PC+1 of the F/D instruction
//   fd_insn         out 32  F/D instruction
//   fd_valid        out 1   F/D holds a real instruction
//   fetch_count     out 32  valid instructions loaded into F/D
//   bubble_count    out 32  bubbles inserted by redirect
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_insn,
  output logic        fd_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus1_p0;
  logic [31:0] pc_next_p0;
  logic [31:0] fd_insn_next_p0;
  logic [31:0] fd_pc_next_p0;
  logic        vld_next_p0;
  logic        load_p0;
  logic        advance_p0;

  // ---- stage p0: PC, next-PC selection and F/D input mux ----
  cla_adder_32 u_pc_inc (
    .a   (pc_p0),
    .b   (32'd1),
    .cin (1'b0),
    .sum (pc_plus1_p0)
  );

  // Redirect overrides stall, so the state registers load whenever either
  // a redirect is present or the pipe is free to advance.
  assign load_p0    = redirect | ~stall;
  assign advance_p0 = ~redirect & ~stall;

  // The word on q_imem during a redirect belongs to the wrong path and is
  // replaced by a bubble.
  assign pc_next_p0      = redirect ? redirect_target : pc_plus1_p0;
  assign fd_insn_next_p0 = redirect ? NOP : q_imem;
  assign fd_pc_next_p0   = redirect ? 32'd0 : pc_plus1_p0;
  assign vld_next_p0     = ~redirect;

  register_en_clr #(.WIDTH(32), .CLR_VAL(RESET_PC)) u_pc_reg (
    .clock (clock),
    .clr   (reset),
    .en    (load_p0),
    .d     (pc_next_p0),
    .q     (pc_p0)
  );

  assign address_imem = pc_p0;

  // ---- stage p1: F/D latch ----
  register_en_clr #(.WIDTH(32), .CLR_VAL(NOP)) u_fd_insn_reg (
    .clock (clock),
    .clr   (reset),
    .en    (load_p0),
    .d     (fd_insn_next_p0),
    .q     (fd_insn)
  );

  register_en_clr #(.WIDTH(32), .CLR_VAL(32'd0)) u_fd_pc_reg (
    .clock (clock),
    .clr   (reset),
    .en    (load_p0),
    .d     (fd_pc_next_p0),
    .q     (fd_pc)
  );

  register_en_clr #(.WIDTH(1), .CLR_VAL(1'b0)) u_fd_vld_reg (
    .clock (clock),
    .clr   (reset),
    .en    (load_p0),
    .d     (vld_next_p0),
    .q     (fd_valid)
  );

  // Performance counters follow the same edge as the F/D latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (redirect) begin
        bubble_count <= wrap_inc(bubble_count);
      end
      if (advance_p0) begin
        fetch_count <= wrap_inc(fetch_count);
      end
    end
  end

endmodule
